ppu_bg_fetch: RTL

- PPU background tile fetch sequencer, directly upstream of the memory manager's PPU port.
- For each tile it issues four reads: nametable, attribute, pattern low plane, pattern high plane.
- It drives ppu_addr/ppu_read_request and captures returned bytes after a fixed read latency.
- It delivers one assembled tile record (attribute bits plus two pattern planes) per tile to the pixel shifter, advancing coarse X with nametable wrap.

---
 rtl/ppu_pkg.sv | 29 ++
 rtl/ppu_bg_fetch_if.sv | 9 +
 rtl/ppu_vaddr_inc.sv | 19 +
 rtl/ppu_bg_fetch.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU background-fetch definitions: FSM encoding, address constants and
// scroll-register field positions.
package ppu_pkg;

  typedef enum logic [3:0] {
    IDLE, NT_REQ, NT_WAIT, AT_REQ, AT_WAIT,
    LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, EMIT, DONE
  } bg_state_e;

  localparam logic [13:0] NT_BASE     = 14'h2000;
  localparam logic [9:0]  AT_OFFSET   = 10'h3C0;
  localparam logic [3:0]  PT_PLANE_HI = 4'h8;

  // vaddr = {fine_y[2:0], nt_sel[1:0], coarse_y[4:0], coarse_x[4:0]}
  localparam int VA_FY_HI = 14;
  localparam int VA_FY_LO = 12;
  localparam int VA_NT_HI = 11;
  localparam int VA_NT_LO = 10;
  localparam int VA_CY_HI = 9;
  localparam int VA_CY_LO = 5;
  localparam int VA_CX_HI = 4;
  localparam int VA_CX_LO = 0;

  // Attribute byte packs four 2x2-tile quadrants; bit 1 of coarse Y/X picks one.
  function automatic logic [2:0] attr_shift(input logic quad_y, input logic quad_x);
    return {quad_y, quad_x, 1'b0};
  endfunction

endpackage

// File: rtl/ppu_bg_fetch_if.sv
// PPU-side read port between the background fetcher (master) and the memory manager (slave).
interface ppu_bg_fetch_if;
  logic [13:0] ppu_addr;
  logic        ppu_read_request;
  logic [7:0]  ppu_rdata;

  modport master (output ppu_addr, output ppu_read_request, input ppu_rdata);
  modport slave  (input ppu_addr, input ppu_read_request, output ppu_rdata);
endinterface

// File: rtl/ppu_vaddr_inc.sv
// Coarse-X increment of the scroll register; wrapping past 31 flips the horizontal nametable.
module ppu_vaddr_inc
  import ppu_pkg::*;
(
  input  logic [14:0] v,
  output logic [14:0] v_next
);

  always_comb begin
    v_next = v;
    if (v[VA_CX_HI:VA_CX_LO] == 5'd31) begin
      v_next[VA_CX_HI:VA_CX_LO] = 5'd0;
      v_next[VA_NT_LO]          = ~v[VA_NT_LO];
    end else begin
      v_next[VA_CX_HI:VA_CX_LO] = v[VA_CX_HI:VA_CX_LO] + 5'd1;
    end
  end

endmodule

// File: rtl/ppu_bg_fetch.sv
// Background tile fetch sequencer: NT/AT/LO/HI reads per tile, one tile record out per tile.
// Optional PPU_BG_FETCH_CNT_EN adds a saturating fetch_count of emitted tiles.
module ppu_bg_fetch
  import ppu_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int MAX_TILES  = 34
)(
  input  logic                clk,
  input  logic                rst,
  ppu_bg_fetch_if.master      mem,
  input  logic                start,
  input  logic [14:0]         vaddr,
  input  logic [5:0]          tile_count,
  input  logic                bg_pt_sel,
  output logic                tile_valid,
  output logic [1:0]          tile_attr,
  output logic [7:0]          tile_lo,
  output logic [7:0]          tile_hi,
  output logic [14:0]         vaddr_next,
  output logic                busy,
  output logic                done
`ifdef PPU_BG_FETCH_CNT_EN
  , output logic [15:0]       fetch_count
`endif
);

  bg_state_e             state;
  logic [14:0]           v, v_inc;
  logic                  pt_sel;
  logic [5:0]            remaining, run_len;
  logic [7:0]            nt_byte, lo_byte;
  logic [1:0]            attr_q, attr_sel;
  logic [13:0]           at_addr, lo_addr;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic                  rd_hit;

  ppu_vaddr_inc u_inc (.v(v), .v_next(v_inc));

  assign run_len = (int'(tile_count) > MAX_TILES) ? 6'(MAX_TILES) : tile_count;

  assign at_addr = NT_BASE
                 | {2'b00, v[VA_NT_HI:VA_NT_LO], 10'h000}
                 | {4'h0, AT_OFFSET}
                 | {8'h00, v[VA_CY_HI:VA_CY_HI-2], v[VA_CX_HI:VA_CX_HI-2]};
  assign lo_addr  = {1'b0, pt_sel, nt_byte, 1'b0, v[VA_FY_HI:VA_FY_LO]};
  assign attr_sel = 2'(mem.ppu_rdata >> attr_shift(v[VA_CY_LO+1], v[VA_CX_LO+1]));

  // Tracks the single outstanding read; the top bit marks the cycle its data is on ppu_rdata.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= mem.ppu_read_request;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end
  assign rd_hit = vld_pipe[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                <= IDLE;
      v                    <= '0;
      pt_sel               <= 1'b0;
      remaining            <= '0;
      nt_byte              <= '0;
      lo_byte              <= '0;
      attr_q               <= '0;
      mem.ppu_addr         <= '0;
      mem.ppu_read_request <= 1'b0;
      tile_valid           <= 1'b0;
      tile_attr            <= '0;
      tile_lo              <= '0;
      tile_hi              <= '0;
      vaddr_next           <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      mem.ppu_read_request <= 1'b0;
      tile_valid           <= 1'b0;
      done                 <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (tile_count != 6'd0) begin
            v                    <= vaddr;
            pt_sel               <= bg_pt_sel;
            remaining            <= run_len;
            mem.ppu_addr         <= NT_BASE | {2'b00, vaddr[11:0]};
            mem.ppu_read_request <= 1'b1;
            state                <= NT_REQ;
          end else begin
            done       <= 1'b1;
            vaddr_next <= v;
            state      <= DONE;
          end
        end
        NT_REQ: state <= NT_WAIT;
        NT_WAIT: if (rd_hit) begin
          nt_byte              <= mem.ppu_rdata;
          mem.ppu_addr         <= at_addr;
          mem.ppu_read_request <= 1'b1;
          state                <= AT_REQ;
        end
        AT_REQ: state <= AT_WAIT;
        AT_WAIT: if (rd_hit) begin
          attr_q               <= attr_sel;
          mem.ppu_addr         <= lo_addr;
          mem.ppu_read_request <= 1'b1;
          state                <= LO_REQ;
        end
        LO_REQ: state <= LO_WAIT;
        LO_WAIT: if (rd_hit) begin
          lo_byte              <= mem.ppu_rdata;
          mem.ppu_addr         <= lo_addr | {10'h000, PT_PLANE_HI};
          mem.ppu_read_request <= 1'b1;
          state                <= HI_REQ;
        end
        HI_REQ: state <= HI_WAIT;
        HI_WAIT: if (rd_hit) begin
          tile_valid <= 1'b1;
          tile_attr  <= attr_q;
          tile_lo    <= lo_byte;
          tile_hi    <= mem.ppu_rdata;
          state      <= EMIT;
        end
        EMIT: begin
          v         <= v_inc;
          remaining <= remaining - 6'd1;
          if (remaining == 6'd1) begin
            done       <= 1'b1;
            vaddr_next <= v_inc;
            state      <= DONE;
          end else begin
            mem.ppu_addr         <= NT_BASE | {2'b00, v_inc[11:0]};
            mem.ppu_read_request <= 1'b1;
            state                <= NT_REQ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PPU_BG_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) fetch_count <= '0;
    else if (tile_valid && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule
